mem_arbiter_ctrl: RTL
=====================

Name: mem_arbiter_ctrl

Overview:
Sequences the single byte-wide RAM port and shares it between instruction fetch and the load/store buffer.
- Turns each 32-bit fetch and each 1/2/4-byte load/store into a stream of byte-serial RAM accesses.
- Reassembles read bytes into a word and honours the IO-buffer-full stall on stores.
- Sits between the fetch unit, the load/store buffer and the top-level RAM pins.

Parameters:
ADDR_W, 32, width of all addresses.
IO_SEL_HI, 17, MSB of the IO-space select field; an address is IO when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11.

Ports:
clk_in  in  1  clock.
rst_in  in  1  synchronous active-high reset.
rdy_in  in  1  global enable; low freezes the block.
clear_in  in  1  control-hazard flush from commit.
if_req  in  1  fetch request; held until if_done or clear.
if_addr  in  ADDR_W  fetch address; stable while if_req.
if_done  out  1  one-cycle pulse; if_data valid.
if_data  out  32  fetched word, little-endian.
ls_req  in  1  load/store request; held until ls_done.
ls_wr  in  1  1 = store.
ls_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as byte).
ls_addr  in  ADDR_W  byte address.
ls_wdata  in  32  store data; low bytes used.
ls_done  out  1  one-cycle pulse.
ls_rdata  out  32  load data, zero-extended; requester sign-extends.
io_buffer_full  in  1  high: IO writes must wait.
mem_din  in  8  RAM read byte; returns one cycle after its address.
mem_dout  out  8  RAM write byte.
mem_a  out  ADDR_W  RAM address.
mem_wr  out  1  1 = write.
busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counters 0.
- Byte count n: 4 for fetch; ls_size 0→1, 1→2, 2→4.
- States and transitions:
  - IDLE: grants a pending request.
  - RD: a read, fetch or load.
    - Issue counter k runs 0..n-1 with mem_a = base+k and mem_wr = 0.
    - Capture counter c lags one cycle; byte c goes to data[8c+7:8c].
    - RD → DONE after byte n-1 is captured.
  - WR: a store.
    - Each cycle: mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
    - WR → DONE after byte n-1 is written.
  - DONE: asserts the owning done pulse for exactly 1 cycle, grants nothing, → IDLE.
- Requesters must drop req on the edge after seeing done.
- Latency, counting the request seen in IDLE as cycle 0:
  - Read: done at cycle n+2 (word fetch 6, byte load 3).
  - Write: done at cycle n+1.
- Address arithmetic is base+k modulo 2^ADDR_W; wrap at the top of memory is legal.
- Outside RD/WR: mem_wr = 0, mem_a = 0, mem_dout = 0.
- Arbitration: ls_req has strict priority over if_req when both are pending in IDLE.
- rdy_in low:
  - State, counters and data registers hold; mem_wr forced 0.
  - On resume, issue restarts at the first uncaptured byte (k = c) for reads and at the current k for writes.
  - A byte counts as captured only if rdy_in was high in both its issue and capture cycles.
- IO stall: in WR, if the address is IO and io_buffer_full = 1, mem_wr = 0 and k holds. The write proceeds in the first cycle io_buffer_full = 0.
- clear_in:
  - In RD: abort; next state IDLE, no done pulse, counters cleared.
  - In WR: ignored; committed stores always complete.
  - In IDLE: suppresses granting any read that cycle, but a store may still be granted.
  - In DONE of a read: done is gated low.
- A new if_addr while not granted is legal; it is sampled only at grant.

Optional Feature:
MEM_ARBITER_RR_EN.
- Defined: a one-bit last-owner register picks round-robin when both requests are pending in IDLE; a store already waiting always wins over a fetch.
- Undefined: ls strict priority as above.
- Reset value of last-owner is "fetch".

Test Plan:
- Fetch only: if_addr = 0x100, RAM bytes 0x13,0x05,0x10,0x00 → mem_a 0x100..0x103 on cycles 1-4; if_done on cycle 6 with if_data = 0x00100513.
- Byte load: ls_size = 0, ls_addr = 0x2003, RAM = 0x80 → ls_done on cycle 3, ls_rdata = 0x00000080.
- Word store: ls_addr = 0x400, wdata = 0xDEADBEEF → mem_wr high cycles 1-4 with mem_dout EF,BE,AD,DE; ls_done on cycle 5.
- IO store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those 3 cycles, then a single write; ls_done on the following cycle.
- Fetch in RD at k = 2 when clear_in pulses → IDLE next cycle, no if_done, mem_wr stays 0. A store mid-WR under clear_in completes all 4 bytes.
- if_req and ls_req together, twice in a row:
  - Without the macro: ls granted both times.
  - With MEM_ARBITER_RR_EN: ls then if.
  - rdy_in dropped for 2 cycles mid-read: data is still correct and done is delayed by at least 2 cycles.

Source files
------------

// File: rtl/mem_arbiter_ctrl_if.sv
// rtl/mem_arbiter_ctrl_if.sv - fetch, load/store and RAM-pin signal bundle for mem_arbiter_ctrl
interface mem_arbiter_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic              io_buffer_full;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  io_buffer_full, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output io_buffer_full, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr, busy
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - byte-serial RAM port sequencer for fetch and load/store (optional MEM_ARBITER_RR_EN round-robin)
module mem_arbiter_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clear_in,
    mem_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       data;
    logic [2:0]        n;
    logic [2:0]        k;
    logic [2:0]        c;
    logic              pend;
    logic              rewind;
    logic              own_ls;
    logic              is_wr;
`ifdef MEM_ARBITER_RR_EN
    logic              last_ls;
`endif

    logic [2:0]        k_cur;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              io_stall;
    logic              ls_ok;
    logic              if_ok;
    logic              grant_ls;
    logic              grant_if;
    logic [2:0]        n_req;

    // Issue pointer, RAM pin drive and grant decision for the current cycle
    always_comb begin
        k_cur    = rewind ? c : k;
        rd_issue = (state == RD) && (k_cur < n);
        rd_addr  = base + ADDR_W'(k_cur);
        wr_addr  = base + ADDR_W'(k);
        io_stall = (state == WR) && (wr_addr[IO_SEL_HI -: 2] == 2'b11) && bus.io_buffer_full;

        bus.mem_a    = '0;
        bus.mem_dout = '0;
        if (rd_issue) begin
            bus.mem_a = rd_addr;
        end else if (state == WR) begin
            bus.mem_a    = wr_addr;
            bus.mem_dout = wdata[{k[1:0], 3'b000} +: 8];
        end
        bus.mem_wr = (state == WR) && rdy_in && !io_stall;

        bus.busy     = (state != IDLE);
        bus.if_data  = data;
        bus.ls_rdata = data;
        bus.if_done  = (state == DONE) && rdy_in && !own_ls && !clear_in;
        bus.ls_done  = (state == DONE) && rdy_in && own_ls && (is_wr || !clear_in);

        ls_ok = bus.ls_req && (bus.ls_wr || !clear_in);
        if_ok = bus.if_req && !clear_in;
`ifdef MEM_ARBITER_RR_EN
        grant_ls = ls_ok && (!if_ok || bus.ls_wr || !last_ls);
`else
        grant_ls = ls_ok;
`endif
        grant_if = if_ok && !grant_ls;

        case (bus.ls_size)
            2'd1:    n_req = 3'd2;
            2'd2:    n_req = 3'd4;
            default: n_req = 3'd1;
        endcase
    end

    // Main sequencer: grant, byte issue/capture, write stream, done
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            base   <= '0;
            wdata  <= '0;
            data   <= '0;
            n      <= '0;
            k      <= '0;
            c      <= '0;
            pend   <= 1'b0;
            rewind <= 1'b0;
            own_ls <= 1'b0;
            is_wr  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_ls <= 1'b0;
`endif
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    k      <= '0;
                    c      <= '0;
                    pend   <= 1'b0;
                    rewind <= 1'b0;
                    if (grant_ls) begin
                        base   <= bus.ls_addr;
                        wdata  <= bus.ls_wdata;
                        n      <= n_req;
                        own_ls <= 1'b1;
                        is_wr  <= bus.ls_wr;
                        data   <= '0;
                        state  <= bus.ls_wr ? WR : RD;
`ifdef MEM_ARBITER_RR_EN
                        last_ls <= 1'b1;
`endif
                    end else if (grant_if) begin
                        base   <= bus.if_addr;
                        n      <= 3'd4;
                        own_ls <= 1'b0;
                        is_wr  <= 1'b0;
                        data   <= '0;
                        state  <= RD;
`ifdef MEM_ARBITER_RR_EN
                        last_ls <= 1'b0;
`endif
                    end
                end
                RD: begin
                    if (clear_in) begin
                        state  <= IDLE;
                        k      <= '0;
                        c      <= '0;
                        pend   <= 1'b0;
                        rewind <= 1'b0;
                    end else begin
                        rewind <= 1'b0;
                        if (pend) begin
                            data[{c[1:0], 3'b000} +: 8] <= bus.mem_din;
                            c <= c + 3'd1;
                            if (c == n - 3'd1) begin
                                state <= DONE;
                            end
                        end
                        if (k_cur < n) begin
                            k    <= k_cur + 3'd1;
                            pend <= 1'b1;
                        end else begin
                            k    <= k_cur;
                            pend <= 1'b0;
                        end
                    end
                end
                WR: begin
                    if (!io_stall) begin
                        k <= k + 3'd1;
                        if (k == n - 3'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end else if (state == RD) begin
            // byte in flight is lost; re-issue from the first uncaptured byte
            pend   <= 1'b0;
            rewind <= 1'b1;
        end
    end
endmodule
